sobel_gcd_unal: RTL and testbench

- TinyTapeout-style top block with two engines:
  - a 3x3 Sobel edge-magnitude engine;
  - an 8-bit iterative GCD engine.
- Both are configured and read through an SPI slave on the bidirectional pins.
- A result byte is also driven on the dedicated outputs, selected by ui_in.
- Sits directly under the chip harness; the only logic between pads and engines.

---
 rtl/sobel_gcd_unal.sv | 258 +++++++++++++++++++++++++
 tb/tb_sobel_gcd_unal.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_gcd_unal.sv
`default_nettype none
// ============================================================================
//  Module   : sobel_gcd_unal
//  Purpose  : Pad-level top holding a 3x3 Sobel edge-magnitude engine and an
//             8-bit subtractive GCD engine. Both are reached through an SPI
//             mode-3 slave on the bidirectional pins. A result byte is also
//             muxed onto the dedicated outputs.
//  Ports    : clk, rst_n (async, active-low), ena (ignored)
//             ui_in[1:0]  : uo_out select (sobel / gcd / status / zero)
//             uo_out      : selected result byte
//             uio_in[2:0] : {SS_n, MOSI, SCK}
//             uio_out[3]  : MISO, every other bit 0
//             uio_oe      : constant 8'b0000_1000
//  Revision : 1.0 - initial release
// ============================================================================
module sobel_gcd_unal #(
  parameter int STREAM_DATA_WIDTH = 16,
  parameter int SYNC_STAGES       = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int               CNT_W     = $clog2(STREAM_DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] C_NBITS   = CNT_W'(STREAM_DATA_WIDTH);
  localparam logic [CNT_W-1:0] C_LASTBIT = CNT_W'(STREAM_DATA_WIDTH - 1);
  localparam logic [7:0]       C_CMD_A   = 8'h10;
  localparam logic [7:0]       C_CMD_B   = 8'h11;
  localparam logic [7:0]       C_CMD_GO  = 8'h12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } gcd_state_e;

  // --------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic sck_prev_q, sck_prev_d, ss_prev_q, ss_prev_d;
  logic sck_s, mosi_s, ss_n_s, sck_rise, sck_fall, ss_fall;

  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], uio_in[0]};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], uio_in[1]};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], uio_in[2]};
    sck_s       = sck_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    ss_n_s      = ss_sync_q[SYNC_STAGES-1];
    sck_prev_d  = sck_s;
    ss_prev_d   = ss_n_s;
    sck_rise    = sck_s & ~sck_prev_q;
    sck_fall    = ~sck_s & sck_prev_q;
    ss_fall     = ~ss_n_s & ss_prev_q;
  end

  // --------------------------------------------------------------------------
  // SPI shift logic
  // --------------------------------------------------------------------------
  logic [STREAM_DATA_WIDTH-1:0] rx_q, rx_d, tx_q, tx_d;
  logic [CNT_W-1:0]             bit_cnt_q, bit_cnt_d;
  logic                         first_fall_q, first_fall_d;
  logic                         frame_done_q, frame_done_d;
  logic [7:0]                   gcd_result_q, gcd_result_d;
  logic [7:0]                   sobel_mag_q, sobel_mag_d;
  logic                         miso;

  always_comb begin
    rx_d         = rx_q;
    tx_d         = tx_q;
    bit_cnt_d    = bit_cnt_q;
    first_fall_d = first_fall_q;
    frame_done_d = 1'b0;
    if (ss_fall) begin
      bit_cnt_d    = '0;
      tx_d         = '0;
      tx_d[STREAM_DATA_WIDTH-1 -: 16] = {gcd_result_q, sobel_mag_q};
      first_fall_d = 1'b1;
    end else if (!ss_n_s) begin
      // Bits beyond the frame length are dropped until SS_n deasserts.
      if (sck_rise && (bit_cnt_q < C_NBITS)) begin
        rx_d         = {rx_q[STREAM_DATA_WIDTH-2:0], mosi_s};
        bit_cnt_d    = bit_cnt_q + 1'b1;
        frame_done_d = (bit_cnt_q == C_LASTBIT);
      end
      // Mode 3: the leading falling edge presents the MSB already loaded,
      // so only later falling edges advance the tx register.
      if (sck_fall) begin
        if (first_fall_q) first_fall_d = 1'b0;
        else              tx_d = {tx_q[STREAM_DATA_WIDTH-2:0], 1'b0};
      end
    end
  end

  assign miso = ~ss_n_s & tx_q[STREAM_DATA_WIDTH-1];

  // --------------------------------------------------------------------------
  // Command decode (one clk after the final rising edge of a full frame)
  // --------------------------------------------------------------------------
  logic       cmd_valid;
  logic [7:0] cmd, cmd_data;
  logic [7:0] pix_q [9];
  logic [7:0] pix_d [9];
  logic [7:0] a_q, a_d, b_q, b_d;

  assign cmd_valid = frame_done_q;
  assign cmd       = rx_q[STREAM_DATA_WIDTH-1 -: 8];
  assign cmd_data  = rx_q[7:0];

  always_comb begin
    for (int i = 0; i < 9; i++) begin
      pix_d[i] = pix_q[i];
      if (cmd_valid && (cmd == 8'(i + 1))) pix_d[i] = cmd_data;
    end
    a_d = (cmd_valid && (cmd == C_CMD_A)) ? cmd_data : a_q;
    b_d = (cmd_valid && (cmd == C_CMD_B)) ? cmd_data : b_q;
  end

  // --------------------------------------------------------------------------
  // Sobel: sums kept as 11-bit two's complement (|G| <= 1020 fits)
  // --------------------------------------------------------------------------
  logic [10:0] gx_pos, gx_neg, gy_pos, gy_neg, gx, gy, gx_abs, gy_abs, mag_sum;

  always_comb begin
    gx_pos      = 11'(pix_q[2]) + {2'b0, pix_q[5], 1'b0} + 11'(pix_q[8]);
    gx_neg      = 11'(pix_q[0]) + {2'b0, pix_q[3], 1'b0} + 11'(pix_q[6]);
    gy_pos      = 11'(pix_q[6]) + {2'b0, pix_q[7], 1'b0} + 11'(pix_q[8]);
    gy_neg      = 11'(pix_q[0]) + {2'b0, pix_q[1], 1'b0} + 11'(pix_q[2]);
    gx          = gx_pos - gx_neg;
    gy          = gy_pos - gy_neg;
    gx_abs      = gx[10] ? (~gx + 11'd1) : gx;
    gy_abs      = gy[10] ? (~gy + 11'd1) : gy;
    mag_sum     = gx_abs + gy_abs;
    sobel_mag_d = (|mag_sum[10:8]) ? 8'hFF : mag_sum[7:0];
  end

  // --------------------------------------------------------------------------
  // GCD FSM
  // --------------------------------------------------------------------------
  gcd_state_e state_q, state_d;
  logic [7:0] x_q, x_d, y_q, y_d;
  logic       done_q, done_d, start, busy;

  assign start = cmd_valid && (cmd == C_CMD_GO);
  assign busy  = (state_q == ST_CALC);

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    gcd_result_d = gcd_result_q;
    done_d       = done_q;
    case (state_q)
      ST_CALC: begin
        if (x_q == 8'd0) begin
          gcd_result_d = y_q;
          done_d       = 1'b1;
          state_d      = ST_DONE;
        end else if ((y_q == 8'd0) || (x_q == y_q)) begin
          gcd_result_d = x_q;
          done_d       = 1'b1;
          state_d      = ST_DONE;
        end else if (x_q > y_q) begin
          x_d = x_q - y_q;
        end else begin
          y_d = y_q - x_q;
        end
      end
      default: begin
        // IDLE and DONE both accept a start; DONE otherwise falls to IDLE.
        if (start) begin
          x_d     = a_q;
          y_d     = b_q;
          done_d  = 1'b0;
          state_d = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q   <= '1;
      mosi_sync_q  <= '0;
      ss_sync_q    <= '1;
      sck_prev_q   <= 1'b1;
      ss_prev_q    <= 1'b1;
      rx_q         <= '0;
      tx_q         <= '0;
      bit_cnt_q    <= '0;
      first_fall_q <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 9; i++) pix_q[i] <= '0;
      a_q          <= '0;
      b_q          <= '0;
      x_q          <= '0;
      y_q          <= '0;
      gcd_result_q <= '0;
      done_q       <= 1'b0;
      sobel_mag_q  <= '0;
      state_q      <= ST_IDLE;
    end else begin
      sck_sync_q   <= sck_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      ss_sync_q    <= ss_sync_d;
      sck_prev_q   <= sck_prev_d;
      ss_prev_q    <= ss_prev_d;
      rx_q         <= rx_d;
      tx_q         <= tx_d;
      bit_cnt_q    <= bit_cnt_d;
      first_fall_q <= first_fall_d;
      frame_done_q <= frame_done_d;
      for (int i = 0; i < 9; i++) pix_q[i] <= pix_d[i];
      a_q          <= a_d;
      b_q          <= b_d;
      x_q          <= x_d;
      y_q          <= y_d;
      gcd_result_q <= gcd_result_d;
      done_q       <= done_d;
      sobel_mag_q  <= sobel_mag_d;
      state_q      <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    case (ui_in[1:0])
      2'b00:   uo_out = sobel_mag_q;
      2'b01:   uo_out = gcd_result_q;
      2'b10:   uo_out = {6'b0, busy, done_q};
      default: uo_out = 8'h00;
    endcase
  end

  assign uio_out = {4'b0, miso, 3'b0};
  assign uio_oe  = 8'b0000_1000;

  logic unused_inputs;
  assign unused_inputs = ^{ena, ui_in[7:2], uio_in[7:3]};

endmodule
`default_nettype wire

// File: tb/tb_sobel_gcd_unal.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_sobel_gcd_unal
//  Purpose  : Self-checking bench for sobel_gcd_unal; drives SPI mode-3
//             frames and compares against an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sobel_gcd_unal;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'b0000_0101;  // SS_n=1, SCK=1 (mode-3 idle)
  logic [7:0] uo_out, uio_out, uio_oe;

  int checks = 0;
  int failures = 0;

  int m_pix[9];
  int m_a = 0, m_b = 0, m_gcd = 0;

  sobel_gcd_unal #(
    .STREAM_DATA_WIDTH(16),
    .SYNC_STAGES      (2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sobel_ref();
    int gx, gy, m;
    gx = (m_pix[2] + 2*m_pix[5] + m_pix[8]) - (m_pix[0] + 2*m_pix[3] + m_pix[6]);
    gy = (m_pix[6] + 2*m_pix[7] + m_pix[8]) - (m_pix[0] + 2*m_pix[1] + m_pix[2]);
    m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (m > 255) ? 255 : m;
  endfunction

  function automatic int gcd_ref(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode-3 master: SCK half-period of 3 clk; MISO sampled at the end of
  // the high phase of each bit.
  task automatic spi_xfer(input logic [15:0] word, input int nbits, output logic [15:0] rd);
    rd = '0;
    uio_in[2] = 1'b0;
    wait_clk(3);
    for (int i = 0; i < nbits; i++) begin
      uio_in[0] = 1'b0;
      uio_in[1] = word[15-i];
      wait_clk(3);
      uio_in[0] = 1'b1;
      wait_clk(3);
      rd[15-i] = uio_out[3];
    end
    uio_in[2] = 1'b1;
    wait_clk(6);
  endtask

  task automatic spi_cmd(input logic [7:0] c, input logic [7:0] d);
    logic [15:0] rd;
    spi_xfer({c, d}, 16, rd);
    if (c >= 8'h01 && c <= 8'h09) m_pix[c-1] = d;
    else if (c == 8'h10) m_a = d;
    else if (c == 8'h11) m_b = d;
  endtask

  task automatic check_sobel(input string tag);
    ui_in = 8'h00;
    #1;
    check_val(tag, uo_out, sobel_ref());
  endtask

  task automatic wait_done(input string tag);
    ui_in = 8'h02;
    #1;
    for (int n = 0; n < 400; n++) begin
      if (uo_out[0] === 1'b1) break;
      @(negedge clk);
    end
    check_val({tag, "_done"}, uo_out[0], 1);
  endtask

  task automatic run_gcd(input string tag, input int a, input int b);
    spi_cmd(8'h10, 8'(a));
    spi_cmd(8'h11, 8'(b));
    spi_cmd(8'h12, 8'h00);
    m_gcd = gcd_ref(m_a, m_b);
    wait_done(tag);
    ui_in = 8'h01;
    #1;
    check_val({tag, "_result"}, uo_out, m_gcd);
  endtask

  task automatic check_all_zero(input string tag);
    for (int s = 0; s < 4; s++) begin
      ui_in = 8'(s);
      #1;
      check_val($sformatf("%s_sel%0d", tag, s), uo_out, 0);
    end
    check_val({tag, "_uio_out"}, uio_out, 0);
    check_val({tag, "_uio_oe"}, uio_oe, 8'h08);
  endtask

  initial begin
    logic [15:0] rd;
    int exp_word;
    for (int i = 0; i < 9; i++) m_pix[i] = 0;

    // Reset state
    #100;
    check_all_zero("in_reset");
    #100;
    @(negedge clk);
    rst_n = 1'b1;
    check_all_zero("post_reset");
    wait_clk(4);

    // Flat image
    for (int i = 1; i <= 9; i++) spi_cmd(8'(i), 8'd100);
    check_sobel("sobel_flat");

    // Strong vertical edge saturates, then a weaker one
    for (int r = 0; r < 3; r++) begin
      spi_cmd(8'(3*r + 1), 8'd0);
      spi_cmd(8'(3*r + 2), 8'd0);
      spi_cmd(8'(3*r + 3), 8'd255);
    end
    check_sobel("sobel_sat");
    check_val("sobel_sat_const", uo_out, 255);
    spi_cmd(8'h03, 8'd10);
    spi_cmd(8'h06, 8'd10);
    spi_cmd(8'h09, 8'd10);
    check_sobel("sobel_40");

    // Random images
    for (int k = 0; k < 4; k++) begin
      for (int i = 1; i <= 9; i++) spi_cmd(8'(i), 8'($urandom_range(0, 255)));
      check_sobel($sformatf("sobel_rand%0d", k));
    end

    // GCD directed cases and MISO readback
    run_gcd("gcd_48_18", 48, 18);
    spi_xfer(16'h0000, 16, rd);
    exp_word = (m_gcd << 8) | sobel_ref();
    check_val("miso_word", rd, exp_word);
    run_gcd("gcd_0_7", 0, 7);
    run_gcd("gcd_0_0", 0, 0);

    // Random GCD pairs
    for (int k = 0; k < 5; k++)
      run_gcd($sformatf("gcd_rand%0d", k), $urandom_range(0, 255), $urandom_range(1, 255));

    // Busy flag, B write and restart during CALC must not disturb the run
    spi_cmd(8'h10, 8'd254);
    spi_cmd(8'h11, 8'd1);
    spi_cmd(8'h12, 8'h00);
    m_gcd = gcd_ref(m_a, m_b);
    ui_in = 8'h02;
    #1;
    check_val("busy_status", uo_out, 8'h02);
    spi_cmd(8'h11, 8'd2);
    spi_cmd(8'h12, 8'h00);
    ui_in = 8'h02;
    #1;
    check_val("busy_after_restart", uo_out[1], 1);
    wait_done("gcd_long");
    ui_in = 8'h01;
    #1;
    check_val("gcd_long_result", uo_out, m_gcd);
    wait_clk(300);
    check_val("gcd_long_hold", uo_out, m_gcd);
    ui_in = 8'h02;
    #1;
    check_val("gcd_long_status", uo_out, 8'h01);

    // Aborted frame leaves A unchanged
    spi_cmd(8'h10, 8'd48);
    spi_cmd(8'h11, 8'd18);
    spi_xfer(16'h10FF, 8, rd);
    spi_cmd(8'h12, 8'h00);
    m_gcd = gcd_ref(m_a, m_b);
    wait_done("abort");
    ui_in = 8'h01;
    #1;
    check_val("abort_result", uo_out, m_gcd);

    // Reset in the middle of a long computation
    spi_cmd(8'h10, 8'd254);
    spi_cmd(8'h11, 8'd1);
    spi_cmd(8'h12, 8'h00);
    wait_clk(50);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) m_pix[i] = 0;
    m_a = 0;
    m_b = 0;
    m_gcd = 0;
    wait_clk(4);
    check_all_zero("after_mid_reset");
    spi_xfer(16'h0000, 16, rd);
    check_val("miso_after_reset", rd, 0);
    run_gcd("gcd_9_6", 9, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
